fetch_queue: RTL and testbench

Parametrised instruction-fetch stage for the next-generation core: it owns the program counter, reads instruction memory one word per cycle, and buffers fetched instructions with their PCs in a small FIFO. Execution consumes them through a valid/ready handshake. It replaces the single-cycle "PC register + increment + branch mux" arrangement with a decoupled front end that supports stalls, branch redirect with flush, and a halt instruction.

---
 rtl/fetch_queue.sv | 136 +++++++++++++
 tb/tb_fetch_queue.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: decoupled instruction-fetch front end. Owns the PC, reads imem one
// word per cycle and buffers {pc, instr} pairs in a small FIFO for the consumer.
//   state   | meaning
//   RUN     | fetching one word per cycle whenever a slot is (or becomes) free
//   HALTED  | halt word fetched; FIFO drains, no fetches until a redirect
module fetch_queue #(
    parameter int                     PC_WIDTH    = 16,
    parameter int                     INSTR_WIDTH = 32,
    parameter int                     DEPTH       = 4,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0] HALT_WORD   = 32'hFFFF_FFFF
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [PC_WIDTH-1:0]      imem_addr,
    input  logic [INSTR_WIDTH-1:0]   imem_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INSTR_WIDTH-1:0]   out_instr,
    output logic [PC_WIDTH-1:0]      out_pc,
    input  logic                     redirect_valid,
    input  logic [PC_WIDTH-1:0]      redirect_target,
    output logic [PC_WIDTH-1:0]      fetch_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     halted
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        S_RUN    = 1'b0,
        S_HALTED = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    fetch_pc_q, fetch_pc_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [PC_WIDTH-1:0]    pc_mem_q [DEPTH];
    logic [PC_WIDTH-1:0]    pc_mem_d [DEPTH];
    logic [INSTR_WIDTH-1:0] instr_mem_q [DEPTH];
    logic [INSTR_WIDTH-1:0] instr_mem_d [DEPTH];

    logic pop;
    logic full;
    logic fetch_en;
    logic is_halt_word;

    // A pop from a full FIFO frees its slot in the same cycle, so full alone does not stall.
    always_comb begin
        pop          = (count_q != '0) && out_ready;
        full         = (count_q == CW'(DEPTH));
        fetch_en     = (state_q == S_RUN) && !redirect_valid && (!full || pop);
        is_halt_word = (imem_data == HALT_WORD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = S_RUN;
        end else if (fetch_en && is_halt_word) begin
            state_d = S_HALTED;
        end
    end

    always_comb begin
        halted = (state_q == S_HALTED);
    end

    // Redirect wins over everything: the word on imem_data this cycle is dropped.
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_target;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (fetch_en) begin
                pc_mem_d[wr_ptr_q]    = fetch_pc_q;
                instr_mem_d[wr_ptr_q] = imem_data;
                wr_ptr_d              = wr_ptr_q + AW'(1);
                fetch_pc_d            = fetch_pc_q + PC_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(fetch_en) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pc_mem_q    <= pc_mem_d;
            instr_mem_q <= instr_mem_d;
        end
    end

    always_comb begin
        imem_addr = fetch_pc_q;
        fetch_pc  = fetch_pc_q;
        count     = count_q;
        out_valid = (count_q != '0);
        out_pc    = out_valid ? pc_mem_q[rd_ptr_q] : '0;
        out_instr = out_valid ? instr_mem_q[rd_ptr_q] : '0;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed table, hand sequences for multi-cycle corners,
// and randomized traffic checked against a queue-based reference model.
module tb_fetch_queue;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk;
    logic        rst;
    logic [15:0] imem_addr;
    logic [31:0] imem_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [15:0] out_pc;
    logic        redirect_valid;
    logic [15:0] redirect_target;
    logic [15:0] fetch_pc;
    logic [2:0]  count;
    logic        halted;

    logic [3:0]  w_imem_addr;
    logic [31:0] w_imem_data;
    logic        w_out_valid;
    logic [31:0] w_out_instr;
    logic [3:0]  w_out_pc;
    logic [3:0]  w_fetch_pc;
    logic [2:0]  w_count;
    logic        w_halted;

    logic        halt_en;
    logic [15:0] halt_addr;

    int n_tests;
    int n_fail;

    fetch_queue dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .fetch_pc(fetch_pc), .count(count), .halted(halted)
    );

    fetch_queue #(.PC_WIDTH(4), .INSTR_WIDTH(32), .DEPTH(4), .RESET_PC(4'd14)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_addr(w_imem_addr), .imem_data(w_imem_data),
        .out_valid(w_out_valid), .out_ready(1'b1),
        .out_instr(w_out_instr), .out_pc(w_out_pc),
        .redirect_valid(1'b0), .redirect_target(4'd0),
        .fetch_pc(w_fetch_pc), .count(w_count), .halted(w_halted)
    );

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        if (halt_en && a == halt_addr) return HALT;
        return 32'h100 + 32'(a);
    endfunction

    assign imem_data   = mem_word(imem_addr);
    assign w_imem_data = 32'h200 + 32'(w_imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a plain queue of fetched entries plus the next fetch address.
    typedef struct packed {
        logic [15:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] m_fpc;
    bit          m_halted;

    task automatic model_reset();
        mq.delete();
        m_fpc    = 16'd0;
        m_halted = 1'b0;
    endtask

    task automatic model_step();
        int          sz;
        bit          pp;
        ent_t        tmp;
        logic [31:0] w;
        if (redirect_valid) begin
            mq.delete();
            m_fpc    = redirect_target;
            m_halted = 1'b0;
        end else begin
            sz = mq.size();
            pp = (sz != 0) && out_ready;
            if (pp) tmp = mq.pop_front();
            if (!m_halted && (sz < 4 || pp)) begin
                w = mem_word(m_fpc);
                mq.push_back('{pc: m_fpc, instr: w});
                if (w == HALT) m_halted = 1'b1;
                m_fpc = m_fpc + 16'd1;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        ent_t h;
        h = (mq.size() != 0) ? mq[0] : '0;
        chk("out_valid", 48'(out_valid), 48'(mq.size() != 0));
        chk("count",     48'(count),     48'(mq.size()));
        chk("fetch_pc",  48'(fetch_pc),  48'(m_fpc));
        chk("imem_addr", 48'(imem_addr), 48'(m_fpc));
        chk("halted",    48'(halted),    48'(m_halted));
        chk("out_pc",    48'(out_pc),    48'(h.pc));
        chk("out_instr", 48'(out_instr), 48'(h.instr));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        out_ready       = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 16'd0;
        rst             = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_valid",  48'(out_valid), 48'd0);
        chk("rst_count",  48'(count),     48'd0);
        chk("rst_fpc",    48'(fetch_pc),  48'd0);
        chk("rst_pc",     48'(out_pc),    48'd0);
        chk("rst_instr",  48'(out_instr), 48'd0);
        chk("rst_halted", 48'(halted),    48'd0);
        chk("rst_wfpc",   48'(w_fetch_pc), 48'd14);
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic        rdy;
        logic        redir;
        logic [15:0] tgt;
        logic        e_valid;
        logic [2:0]  e_count;
        logic [15:0] e_fpc;
        logic [15:0] e_pc;
    } vec_t;

    vec_t vecs[15];
    int   got[$];

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        halt_en   = 1'b0;
        halt_addr = 16'd0;

        vecs[0]  = '{1'b0, 1'b0, 16'h0,  1'b1, 3'd1, 16'd1,  16'd0};
        vecs[1]  = '{1'b0, 1'b0, 16'h0,  1'b1, 3'd2, 16'd2,  16'd0};
        vecs[2]  = '{1'b0, 1'b0, 16'h0,  1'b1, 3'd3, 16'd3,  16'd0};
        vecs[3]  = '{1'b0, 1'b0, 16'h0,  1'b1, 3'd4, 16'd4,  16'd0};
        vecs[4]  = '{1'b0, 1'b0, 16'h0,  1'b1, 3'd4, 16'd4,  16'd0};
        vecs[5]  = '{1'b0, 1'b0, 16'h0,  1'b1, 3'd4, 16'd4,  16'd0};
        vecs[6]  = '{1'b0, 1'b0, 16'h0,  1'b1, 3'd4, 16'd4,  16'd0};
        vecs[7]  = '{1'b0, 1'b0, 16'h0,  1'b1, 3'd4, 16'd4,  16'd0};
        vecs[8]  = '{1'b1, 1'b0, 16'h0,  1'b1, 3'd4, 16'd5,  16'd1};
        vecs[9]  = '{1'b1, 1'b0, 16'h0,  1'b1, 3'd4, 16'd6,  16'd2};
        vecs[10] = '{1'b1, 1'b0, 16'h0,  1'b1, 3'd4, 16'd7,  16'd3};
        vecs[11] = '{1'b1, 1'b0, 16'h0,  1'b1, 3'd4, 16'd8,  16'd4};
        vecs[12] = '{1'b0, 1'b1, 16'h20, 1'b0, 3'd0, 16'h20, 16'd0};
        vecs[13] = '{1'b1, 1'b0, 16'h0,  1'b1, 3'd1, 16'h21, 16'h20};
        vecs[14] = '{1'b1, 1'b0, 16'h0,  1'b1, 3'd1, 16'h22, 16'h21};

        // Streaming after reset, with the narrow-PC instance wrapping alongside.
        do_reset();
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("stream_valid", 48'(out_valid), 48'd1);
            chk("stream_pc",    48'(out_pc),    48'(k - 1));
            chk("stream_instr", 48'(out_instr), 48'(32'h100 + k - 1));
            chk("stream_count", 48'(count),     48'd1);
            if (k <= 4) chk("wrap_pc", 48'(w_out_pc), 48'((14 + k - 1) % 16));
        end

        // Backpressure to full, release, redirect from full.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            out_ready       = vecs[i].rdy;
            redirect_valid  = vecs[i].redir;
            redirect_target = vecs[i].tgt;
            tick();
            chk("vec_valid", 48'(out_valid), 48'(vecs[i].e_valid));
            chk("vec_count", 48'(count),     48'(vecs[i].e_count));
            chk("vec_fpc",   48'(fetch_pc),  48'(vecs[i].e_fpc));
            chk("vec_pc",    48'(out_pc),    48'(vecs[i].e_pc));
            chk("vec_instr", 48'(out_instr),
                vecs[i].e_valid ? 48'(32'h100 + 32'(vecs[i].e_pc)) : 48'd0);
        end
        redirect_valid = 1'b0;

        // Redirect with three entries buffered.
        do_reset();
        for (int i = 0; i < 3; i++) tick();
        chk("redir_pre_count", 48'(count), 48'd3);
        redirect_valid  = 1'b1;
        redirect_target = 16'h20;
        tick();
        chk("redir_count", 48'(count),    48'd0);
        chk("redir_fpc",   48'(fetch_pc), 48'h20);
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        tick();
        chk("redir_first_pc", 48'(out_pc), 48'h20);
        tick();
        chk("redir_second_pc", 48'(out_pc), 48'h21);

        // Halt at address 5, then resume via redirect to 9.
        halt_en   = 1'b1;
        halt_addr = 16'd5;
        do_reset();
        out_ready = 1'b1;
        got.delete();
        for (int i = 0; i < 10; i++) begin
            if (out_valid && out_ready) got.push_back(int'(out_pc));
            tick();
        end
        chk("halt_n_delivered", 48'(got.size()), 48'd6);
        for (int i = 0; i < got.size() && i < 6; i++) chk("halt_order", 48'(got[i]), 48'(i));
        chk("halt_flag", 48'(halted),   48'd1);
        chk("halt_fpc",  48'(fetch_pc), 48'd6);
        chk("halt_cnt",  48'(count),    48'd0);
        redirect_valid  = 1'b1;
        redirect_target = 16'd9;
        tick();
        chk("resume_halted", 48'(halted),   48'd0);
        chk("resume_fpc",    48'(fetch_pc), 48'd9);
        redirect_valid = 1'b0;
        tick();
        chk("resume_pc", 48'(out_pc), 48'd9);
        halt_en = 1'b0;

        // Asynchronous reset pulse between edges while two entries are buffered.
        do_reset();
        tick();
        tick();
        chk("areset_pre_count", 48'(count), 48'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("areset_valid", 48'(out_valid), 48'd0);
        chk("areset_count", 48'(count),     48'd0);
        chk("areset_fpc",   48'(fetch_pc),  48'd0);
        #1;
        rst = 1'b0;
        model_reset();
        out_ready = 1'b1;
        tick();
        chk("areset_restart_pc", 48'(out_pc), 48'd0);

        // Randomized traffic with halts, redirects and PC wrap.
        halt_en   = 1'b1;
        halt_addr = 16'd5;
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 3))
                0:       redirect_target = 16'hFFFD;
                1:       redirect_target = 16'($urandom);
                default: redirect_target = 16'($urandom_range(0, 8));
            endcase
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
